// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads instruction words over a req/ack
// handshake, latches them into IR and turns a stalled memory into a sticky fault.
module instr_fetch_unit #(
  parameter int              PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              TIMEOUT  = 255
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            fetch_start,
  input  logic            pc_load,
  input  logic [PC_W-1:0] pc_load_value,
  output logic            mem_rd,
  output logic [PC_W-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [31:0]     mem_rdata,
  output logic [31:0]     IR,
  output logic            ir_valid,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus4,
  output logic            busy,
  output logic            fault
);

  typedef enum logic [1:0] {IDLE, WAIT, FAULT} state_t;

  localparam logic [15:0]     TIMEOUT_C = 16'(TIMEOUT);
  localparam logic [PC_W-1:0] ALIGN_M   = ~PC_W'(3);

  state_t          state_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pend_q;
  logic            pend_vld_q;
  logic [31:0]     ir_q;
  logic            ir_valid_q;
  logic [15:0]     cnt_q;

  logic [PC_W-1:0] load_tgt_d;
  logic [PC_W-1:0] pc_inc_d;
  logic [15:0]     cnt_d;

  assign load_tgt_d = pc_load_value & ALIGN_M;
  assign pc_inc_d   = pc_q + PC_W'(4);
  assign cnt_d      = cnt_q + 16'd1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // A same-cycle load lands first so the fetch below reads the new target.
          if (pc_load) pc_q <= load_tgt_d;
          if (fetch_start) begin
            state_q    <= WAIT;
            ir_valid_q <= 1'b0;
            cnt_q      <= '0;
          end
        end
        WAIT: begin
          if (mem_ack) begin
            ir_q       <= mem_rdata;
            ir_valid_q <= 1'b1;
            cnt_q      <= '0;
            pend_vld_q <= 1'b0;
            state_q    <= IDLE;
            if (pc_load)         pc_q <= load_tgt_d;
            else if (pend_vld_q) pc_q <= pend_q;
            else                 pc_q <= pc_inc_d;
          end else begin
            // Address must stay stable until ack, so a branch waits in pend_q.
            if (pc_load) begin
              pend_q     <= load_tgt_d;
              pend_vld_q <= 1'b1;
            end
            cnt_q <= cnt_d;
            if (cnt_d == TIMEOUT_C) state_q <= FAULT;
          end
        end
        FAULT: state_q <= FAULT;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_rd   = (state_q == WAIT);
  assign busy     = (state_q == WAIT);
  assign fault    = (state_q == FAULT);
  assign mem_addr = pc_q;
  assign pc       = pc_q;
  assign pc_plus4 = pc_inc_d;
  assign IR       = ir_q;
  assign ir_valid = ir_valid_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a default-timeout instance for fetch/PC
// behaviour and a TIMEOUT=4 instance for the fault path.
module tb_instr_fetch_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;

  logic        fetch_start = 1'b0, pc_load = 1'b0, mem_ack = 1'b0;
  logic [63:0] pc_load_value = '0;
  logic [31:0] mem_rdata = '0;
  logic        mem_rd, ir_valid, busy, fault;
  logic [63:0] mem_addr, pc, pc_plus4;
  logic [31:0] IR;

  logic        t_fetch = 1'b0, t_load = 1'b0, t_ack = 1'b0;
  logic [63:0] t_load_value = '0;
  logic [31:0] t_rdata = '0;
  logic        t_mem_rd, t_ir_valid, t_busy, t_fault;
  logic [63:0] t_mem_addr, t_pc, t_pc_plus4;
  logic [31:0] t_IR;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  instr_fetch_unit #(.PC_W(64), .RESET_PC(64'h0), .TIMEOUT(255)) u_dut (
    .clock(clock), .reset(reset), .fetch_start(fetch_start), .pc_load(pc_load),
    .pc_load_value(pc_load_value), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .IR(IR), .ir_valid(ir_valid),
    .pc(pc), .pc_plus4(pc_plus4), .busy(busy), .fault(fault)
  );

  instr_fetch_unit #(.PC_W(64), .RESET_PC(64'h0), .TIMEOUT(4)) u_dut_to (
    .clock(clock), .reset(reset), .fetch_start(t_fetch), .pc_load(t_load),
    .pc_load_value(t_load_value), .mem_rd(t_mem_rd), .mem_addr(t_mem_addr),
    .mem_ack(t_ack), .mem_rdata(t_rdata), .IR(t_IR), .ir_valid(t_ir_valid),
    .pc(t_pc), .pc_plus4(t_pc_plus4), .busy(t_busy), .fault(t_fault)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    step();
    step();
    chk("rst_pc", pc, 64'h0);
    chk("rst_ir", 64'(IR), 64'h0);
    chk("rst_irv", 64'(ir_valid), 64'h0);
    chk("rst_memrd", 64'(mem_rd), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_fault", 64'(fault), 64'h0);
    chk("rst_pc4", pc_plus4, 64'h4);
    reset = 1'b0;
    step();

    // Zero-wait fetch
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    chk("f1_memrd", 64'(mem_rd), 64'h1);
    chk("f1_addr", mem_addr, 64'h0);
    chk("f1_busy", 64'(busy), 64'h1);
    mem_ack = 1'b1; mem_rdata = 32'h8B02_0020;
    step();
    mem_ack = 1'b0;
    chk("f1_ir", 64'(IR), 64'h8B02_0020);
    chk("f1_irv", 64'(ir_valid), 64'h1);
    chk("f1_pc", pc, 64'h4);
    chk("f1_busy_lo", 64'(busy), 64'h0);
    chk("f1_memrd_lo", 64'(mem_rd), 64'h0);

    // Ack delayed by 5 cycles: request held for 6
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("f2_memrd", 64'(mem_rd), 64'h1);
      chk("f2_addr", mem_addr, 64'h4);
      chk("f2_ir_hold", 64'(IR), 64'h8B02_0020);
      chk("f2_irv_lo", 64'(ir_valid), 64'h0);
      step();
    end
    chk("f2_memrd6", 64'(mem_rd), 64'h1);
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    step();
    mem_ack = 1'b0;
    chk("f2_ir", 64'(IR), 64'h1234_5678);
    chk("f2_pc", pc, 64'h8);

    // Ack outside WAIT is ignored
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    step();
    mem_ack = 1'b0;
    chk("idle_ack_ir", 64'(IR), 64'h1234_5678);
    chk("idle_ack_pc", pc, 64'h8);

    // Load in IDLE, misaligned target is forced to word alignment
    pc_load = 1'b1; pc_load_value = 64'h103;
    step();
    pc_load = 1'b0;
    chk("ld_idle_pc", pc, 64'h100);
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    chk("ld_idle_addr", mem_addr, 64'h100);
    mem_ack = 1'b1; mem_rdata = 32'h1;
    step();
    mem_ack = 1'b0;
    chk("ld_idle_pc4", pc, 64'h104);

    // Load mid-WAIT is deferred to completion
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    pc_load = 1'b1; pc_load_value = 64'h200;
    step();
    pc_load = 1'b0;
    chk("ld_wait_hold", pc, 64'h104);
    chk("ld_wait_addr", mem_addr, 64'h104);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("ld_wait_pc", pc, 64'h200);

    // Two loads mid-WAIT: latest wins
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    pc_load = 1'b1; pc_load_value = 64'h200;
    step();
    pc_load_value = 64'h300;
    step();
    pc_load = 1'b0;
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("ld2_pc", pc, 64'h300);

    // Load on the ack cycle itself
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    pc_load = 1'b1; pc_load_value = 64'h40B; mem_ack = 1'b1;
    step();
    pc_load = 1'b0; mem_ack = 1'b0;
    chk("ld_ack_pc", pc, 64'h408);

    // Load plus fetch together, then wrap at top of address space
    pc_load = 1'b1; pc_load_value = 64'hFFFF_FFFF_FFFF_FFFC; fetch_start = 1'b1;
    step();
    pc_load = 1'b0; fetch_start = 1'b0;
    chk("wrap_addr", mem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_pc4", pc_plus4, 64'h0);
    mem_ack = 1'b1; mem_rdata = 32'hA5A5_0001;
    step();
    mem_ack = 1'b0;
    chk("wrap_pc", pc, 64'h0);

    // Async reset mid-WAIT
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    chk("rw_busy", 64'(busy), 64'h1);
    #2 reset = 1'b1;
    #1;
    chk("rw_pc", pc, 64'h0);
    chk("rw_irv", 64'(ir_valid), 64'h0);
    chk("rw_memrd", 64'(mem_rd), 64'h0);
    chk("rw_ir", 64'(IR), 64'h0);
    step();
    reset = 1'b0;
    step();

    // Timeout instance: one good fetch, then a stalled one
    t_fetch = 1'b1;
    step();
    t_fetch = 1'b0;
    t_ack = 1'b1; t_rdata = 32'hCAFE_F00D;
    step();
    t_ack = 1'b0;
    chk("to_ir0", 64'(t_IR), 64'hCAFE_F00D);
    t_fetch = 1'b1;
    step();
    t_fetch = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("to_pre_fault", 64'(t_fault), 64'h0);
      chk("to_pre_memrd", 64'(t_mem_rd), 64'h1);
    end
    step();
    chk("to_fault", 64'(t_fault), 64'h1);
    chk("to_memrd", 64'(t_mem_rd), 64'h0);
    chk("to_busy", 64'(t_busy), 64'h0);
    chk("to_ir_keep", 64'(t_IR), 64'hCAFE_F00D);
    chk("to_irv_keep", 64'(t_ir_valid), 64'h0);
    t_fetch = 1'b1; t_ack = 1'b1; t_rdata = 32'h0BAD_0BAD;
    t_load = 1'b1; t_load_value = 64'h800;
    step();
    step();
    t_fetch = 1'b0; t_ack = 1'b0; t_load = 1'b0;
    chk("to_sticky", 64'(t_fault), 64'h1);
    chk("to_ign_ir", 64'(t_IR), 64'hCAFE_F00D);
    chk("to_ign_pc", t_pc, 64'h4);
    chk("to_ign_memrd", 64'(t_mem_rd), 64'h0);
    #2 reset = 1'b1;
    #1;
    chk("to_rst_fault", 64'(t_fault), 64'h0);
    chk("to_rst_ir", 64'(t_IR), 64'h0);
    chk("to_rst_pc", t_pc, 64'h0);
    step();
    reset = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
